// File: rtl/motor_drive_seq.sv
// Drive sequencer for the Motor block: soft-ramps duty toward a commanded target and
// inserts brake -> dead-time -> re-enable on mode changes. Optional watchdog: MOTOR_DRIVE_WDOG_EN.
module motor_drive_seq #(
    parameter int RAMP_TICKS = 100_000,
    parameter int STEP       = 8,
    parameter int DEAD_TICKS = 1_000_000
`ifdef MOTOR_DRIVE_WDOG_EN
    ,
    parameter int WDOG_TICKS = 50_000_000
`endif
) (
    input  logic       c100MHz,
    input  logic       rst,
    input  logic       estop,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [9:0] cmd_speed,
    output logic [1:0] mode,
    output logic [9:0] speed,
    output logic       busy,
    output logic       at_target
`ifdef MOTOR_DRIVE_WDOG_EN
    ,
    output logic       wdog_trip
`endif
);

    typedef enum logic [1:0] {IDLE, RAMP, BRAKE, DEAD} state_t;

    localparam int RampW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam int DeadW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [RampW-1:0] RampLast = RampW'(RAMP_TICKS - 1);
    localparam logic [DeadW-1:0] DeadLast = DeadW'(DEAD_TICKS - 1);
    localparam logic [10:0]      StepW    = 11'(STEP);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [9:0]       speed_q, speed_d;
    logic [1:0]       tgtMode_q, tgtMode_d;
    logic [9:0]       tgtSpeed_q, tgtSpeed_d;
    logic [RampW-1:0] rampCnt_q, rampCnt_d;
    logic [DeadW-1:0] deadCnt_q, deadCnt_d;

`ifdef MOTOR_DRIVE_WDOG_EN
    localparam int WdogW = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS) : 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_TICKS - 1);
    logic [WdogW-1:0] wdogCnt_q, wdogCnt_d;
    logic             wdogTrip_q, wdogTrip_d;
`endif

    logic        accept;
    logic        rampTick;
    logic [10:0] upDiff, dnDiff, upStep, dnStep, brkStep;
    logic [9:0]  rampNext, brkNext;

    assign accept    = cmd_valid && !estop;
    assign cmd_ready = !estop;
    assign rampTick  = (rampCnt_q == RampLast);

    // Step arithmetic is done at 11 bits so the clamp to the target can never wrap.
    always_comb begin
        upDiff  = 11'(tgtSpeed_q) - 11'(speed_q);
        dnDiff  = 11'(speed_q) - 11'(tgtSpeed_q);
        upStep  = (upDiff < StepW) ? upDiff : StepW;
        dnStep  = (dnDiff < StepW) ? dnDiff : StepW;
        brkStep = (11'(speed_q) < StepW) ? 11'(speed_q) : StepW;
        brkNext = 10'(11'(speed_q) - brkStep);
        if (tgtSpeed_q > speed_q) begin
            rampNext = 10'(11'(speed_q) + upStep);
        end else begin
            rampNext = 10'(11'(speed_q) - dnStep);
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        speed_d    = speed_q;
        tgtMode_d  = tgtMode_q;
        tgtSpeed_d = tgtSpeed_q;
        rampCnt_d  = rampCnt_q;
        deadCnt_d  = deadCnt_q;
`ifdef MOTOR_DRIVE_WDOG_EN
        wdogCnt_d  = wdogCnt_q;
        wdogTrip_d = wdogTrip_q;
`endif

        if (accept) begin
            tgtMode_d  = cmd_mode;
            tgtSpeed_d = (cmd_mode == 2'b00) ? 10'd0 : cmd_speed;
        end

        case (state_q)
            IDLE: begin
                if (tgtMode_q != mode_q && speed_q == 10'd0) begin
                    mode_d = tgtMode_q;
                    if (tgtSpeed_q != 10'd0) begin
                        state_d   = RAMP;
                        rampCnt_d = '0;
                    end
                end else if (tgtMode_q != mode_q) begin
                    state_d   = BRAKE;
                    rampCnt_d = '0;
                end else if (tgtSpeed_q != speed_q) begin
                    state_d   = RAMP;
                    rampCnt_d = '0;
                end
            end
            RAMP: begin
                if (tgtMode_q != mode_q) begin
                    state_d   = BRAKE;
                    rampCnt_d = '0;
                end else if (speed_q == tgtSpeed_q) begin
                    state_d = IDLE;
                end else begin
                    rampCnt_d = rampTick ? '0 : rampCnt_q + 1'b1;
                    if (rampTick) begin
                        speed_d = rampNext;
                        if (rampNext == tgtSpeed_q) state_d = IDLE;
                    end
                end
            end
            BRAKE: begin
                if (speed_q == 10'd0) begin
                    mode_d    = 2'b00;
                    deadCnt_d = '0;
                    state_d   = DEAD;
                end else begin
                    rampCnt_d = rampTick ? '0 : rampCnt_q + 1'b1;
                    if (rampTick) speed_d = brkNext;
                end
            end
            DEAD: begin
                if (deadCnt_q == DeadLast) begin
                    mode_d = tgtMode_q;
                    if (tgtSpeed_q != 10'd0) begin
                        state_d   = RAMP;
                        rampCnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    deadCnt_d = deadCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MOTOR_DRIVE_WDOG_EN
        // A trip only retargets to stop; the normal brake and dead-time path does the rest.
        if (accept) begin
            wdogCnt_d  = '0;
            wdogTrip_d = 1'b0;
        end else if (wdogCnt_q == WdogLast) begin
            if (!wdogTrip_q) begin
                tgtMode_d  = 2'b00;
                tgtSpeed_d = 10'd0;
                wdogTrip_d = 1'b1;
            end
        end else begin
            wdogCnt_d = wdogCnt_q + 1'b1;
        end
`endif

        if (estop) begin
            state_d    = IDLE;
            mode_d     = 2'b00;
            speed_d    = 10'd0;
            tgtMode_d  = 2'b00;
            tgtSpeed_d = 10'd0;
            rampCnt_d  = '0;
            deadCnt_d  = '0;
`ifdef MOTOR_DRIVE_WDOG_EN
            wdogCnt_d  = '0;
`endif
        end
    end

    always_ff @(posedge c100MHz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            speed_q    <= 10'd0;
            tgtMode_q  <= 2'b00;
            tgtSpeed_q <= 10'd0;
            rampCnt_q  <= '0;
            deadCnt_q  <= '0;
`ifdef MOTOR_DRIVE_WDOG_EN
            wdogCnt_q  <= '0;
            wdogTrip_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            speed_q    <= speed_d;
            tgtMode_q  <= tgtMode_d;
            tgtSpeed_q <= tgtSpeed_d;
            rampCnt_q  <= rampCnt_d;
            deadCnt_q  <= deadCnt_d;
`ifdef MOTOR_DRIVE_WDOG_EN
            wdogCnt_q  <= wdogCnt_d;
            wdogTrip_q <= wdogTrip_d;
`endif
        end
    end

    assign mode      = mode_q;
    assign speed     = speed_q;
    assign busy      = (state_q != IDLE);
    assign at_target = (state_q == IDLE) && (mode_q == tgtMode_q) && (speed_q == tgtSpeed_q);
`ifdef MOTOR_DRIVE_WDOG_EN
    assign wdog_trip = wdogTrip_q;
`endif

endmodule

// File: tb/tb_motor_drive_seq.sv
// Scoreboard bench for motor_drive_seq: every (mode, speed) change is popped against
// a queued expectation that carries the value and the cycle it must appear on.
module tb_motor_drive_seq;

    typedef struct {
        logic [1:0] mode;
        logic [9:0] speed;
        int         cyc;
    } evt_t;

    logic       clk, rst, estop;
    logic       cmdValidA, cmdValidB;
    logic [1:0] cmdModeA, cmdModeB;
    logic [9:0] cmdSpeedA, cmdSpeedB;
    logic       cmdReadyA, cmdReadyB;
    logic [1:0] modeA, modeB;
    logic [9:0] speedA, speedB;
    logic       busyA, busyB, atTargetA, atTargetB;
`ifdef MOTOR_DRIVE_WDOG_EN
    logic       wdogTripA, wdogTripB;
`endif

    int   cyc = 0;
    int   checkCount = 0;
    int   passCount = 0;
    evt_t expA[$];
    evt_t expB[$];
    evt_t evtA, evtB;
    logic [11:0] prevA, prevB;

    motor_drive_seq #(
        .RAMP_TICKS(4), .STEP(8), .DEAD_TICKS(10)
`ifdef MOTOR_DRIVE_WDOG_EN
        , .WDOG_TICKS(200)
`endif
    ) u_dutA (
        .c100MHz(clk), .rst(rst), .estop(estop),
        .cmd_valid(cmdValidA), .cmd_ready(cmdReadyA),
        .cmd_mode(cmdModeA), .cmd_speed(cmdSpeedA),
        .mode(modeA), .speed(speedA), .busy(busyA), .at_target(atTargetA)
`ifdef MOTOR_DRIVE_WDOG_EN
        , .wdog_trip(wdogTripA)
`endif
    );

    motor_drive_seq #(
        .RAMP_TICKS(4), .STEP(600), .DEAD_TICKS(10)
`ifdef MOTOR_DRIVE_WDOG_EN
        , .WDOG_TICKS(200)
`endif
    ) u_dutB (
        .c100MHz(clk), .rst(rst), .estop(estop),
        .cmd_valid(cmdValidB), .cmd_ready(cmdReadyB),
        .cmd_mode(cmdModeB), .cmd_speed(cmdSpeedB),
        .mode(modeB), .speed(speedB), .busy(busyB), .at_target(atTargetB)
`ifdef MOTOR_DRIVE_WDOG_EN
        , .wdog_trip(wdogTripB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic pushEvt(input int inst, input logic [1:0] m, input logic [9:0] s, input int c);
        evt_t e;
        e.mode  = m;
        e.speed = s;
        e.cyc   = c;
        if (inst == 0) expA.push_back(e);
        else           expB.push_back(e);
    endtask

    // Drives one command for a single cycle; acc returns the edge number that accepts it.
    task automatic applyStimulus(input int inst, input logic [1:0] m, input logic [9:0] s, output int acc);
        @(negedge clk);
        if (inst == 0) begin
            cmdValidA = 1'b1; cmdModeA = m; cmdSpeedA = s;
        end else begin
            cmdValidB = 1'b1; cmdModeB = m; cmdSpeedB = s;
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        cmdValidA = 1'b0;
        cmdValidB = 1'b0;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic waitDrain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (expA.size() == 0 && expB.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checkOutput("queue drained", expA.size() + expB.size(), 0);
    endtask

    // Every observable change must match the head of the queue, including its cycle stamp.
    always @(negedge clk) begin
        if (rst) begin
            prevA = {modeA, speedA};
        end else if ({modeA, speedA} != prevA) begin
            if (expA.size() == 0) begin
                checkOutput("A unexpected change", int'({modeA, speedA}), int'(prevA));
            end else begin
                evtA = expA.pop_front();
                checkOutput("A mode", modeA, evtA.mode);
                checkOutput("A speed", speedA, evtA.speed);
                checkOutput("A change cycle", cyc, evtA.cyc);
            end
            prevA = {modeA, speedA};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prevB = {modeB, speedB};
        end else if ({modeB, speedB} != prevB) begin
            if (expB.size() == 0) begin
                checkOutput("B unexpected change", int'({modeB, speedB}), int'(prevB));
            end else begin
                evtB = expB.pop_front();
                checkOutput("B mode", modeB, evtB.mode);
                checkOutput("B speed", speedB, evtB.speed);
                checkOutput("B change cycle", cyc, evtB.cyc);
            end
            prevB = {modeB, speedB};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int a;
        rst = 1'b1; estop = 1'b0;
        cmdValidA = 1'b0; cmdModeA = 2'b00; cmdSpeedA = 10'd0;
        cmdValidB = 1'b0; cmdModeB = 2'b00; cmdSpeedB = 10'd0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset mode", modeA, 0);
        checkOutput("reset speed", speedA, 0);
        checkOutput("reset busy", busyA, 0);
        checkOutput("reset at_target", atTargetA, 1);
        checkOutput("reset cmd_ready", cmdReadyA, 1);
`ifdef MOTOR_DRIVE_WDOG_EN
        checkOutput("reset wdog_trip", wdogTripA, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] ramp up 00/0 -> 11/40");
        applyStimulus(0, 2'b11, 10'd40, a);
        pushEvt(0, 2'b11, 10'd0, a + 1);
        pushEvt(0, 2'b11, 10'd8, a + 5);
        pushEvt(0, 2'b11, 10'd16, a + 9);
        pushEvt(0, 2'b11, 10'd24, a + 13);
        pushEvt(0, 2'b11, 10'd32, a + 17);
        pushEvt(0, 2'b11, 10'd40, a + 21);
        waitUntil(a + 2);
        checkOutput("ramp busy", busyA, 1);
        checkOutput("ramp at_target", atTargetA, 0);
        waitDrain(40);
        checkOutput("ramp done busy", busyA, 0);
        checkOutput("ramp done at_target", atTargetA, 1);

        $display("[TB] small step down 40 -> 37");
        applyStimulus(0, 2'b11, 10'd37, a);
        pushEvt(0, 2'b11, 10'd37, a + 5);
        waitUntil(a + 3);
        checkOutput("step busy", busyA, 1);
        waitDrain(20);
        waitUntil(a + 12);
        checkOutput("step at_target", atTargetA, 1);
        applyStimulus(0, 2'b11, 10'd40, a);
        pushEvt(0, 2'b11, 10'd40, a + 5);
        waitDrain(20);

        $display("[TB] mode change 11/40 -> 01/20");
        applyStimulus(0, 2'b01, 10'd20, a);
        pushEvt(0, 2'b11, 10'd32, a + 5);
        pushEvt(0, 2'b11, 10'd24, a + 9);
        pushEvt(0, 2'b11, 10'd16, a + 13);
        pushEvt(0, 2'b11, 10'd8, a + 17);
        pushEvt(0, 2'b11, 10'd0, a + 21);
        pushEvt(0, 2'b00, 10'd0, a + 22);
        pushEvt(0, 2'b01, 10'd0, a + 32);
        pushEvt(0, 2'b01, 10'd8, a + 36);
        pushEvt(0, 2'b01, 10'd16, a + 40);
        pushEvt(0, 2'b01, 10'd20, a + 44);
        waitUntil(a + 27);
        checkOutput("dead busy", busyA, 1);
        checkOutput("dead at_target", atTargetA, 0);
        waitDrain(80);
        checkOutput("reenable at_target", atTargetA, 1);
        checkOutput("reenable busy", busyA, 0);

        $display("[TB] estop mid-ramp");
        @(negedge clk);
        pushEvt(0, 2'b00, 10'd0, cyc + 1);
        estop = 1'b1;
        @(negedge clk);
        estop = 1'b0;
        waitDrain(10);
        applyStimulus(0, 2'b11, 10'd40, a);
        pushEvt(0, 2'b11, 10'd0, a + 1);
        pushEvt(0, 2'b11, 10'd8, a + 5);
        pushEvt(0, 2'b11, 10'd16, a + 9);
        pushEvt(0, 2'b11, 10'd24, a + 13);
        waitUntil(a + 13);
        estop = 1'b1;
        cmdValidA = 1'b1; cmdModeA = 2'b10; cmdSpeedA = 10'd100;
        pushEvt(0, 2'b00, 10'd0, a + 14);
        #1;
        checkOutput("estop cmd_ready", cmdReadyA, 0);
        @(negedge clk);
        #1;
        checkOutput("estop busy", busyA, 0);
        checkOutput("estop held cmd_ready", cmdReadyA, 0);
        repeat (2) @(negedge clk);
        estop = 1'b0;
        cmdValidA = 1'b0;
        #1;
        checkOutput("estop release cmd_ready", cmdReadyA, 1);
        checkOutput("estop release at_target", atTargetA, 1);
        waitDrain(10);
        waitUntil(cyc + 10);
        checkOutput("estop dropped cmd mode", modeA, 0);
        checkOutput("estop dropped cmd busy", busyA, 0);

        $display("[TB] large step 600 without wrap");
        applyStimulus(1, 2'b11, 10'd1023, a);
        pushEvt(1, 2'b11, 10'd0, a + 1);
        pushEvt(1, 2'b11, 10'd600, a + 5);
        pushEvt(1, 2'b11, 10'd1023, a + 9);
        waitDrain(20);
        checkOutput("B full at_target", atTargetB, 1);
        applyStimulus(1, 2'b11, 10'd0, a);
        pushEvt(1, 2'b11, 10'd423, a + 5);
        pushEvt(1, 2'b11, 10'd0, a + 9);
        waitDrain(20);
        checkOutput("B zero mode", modeB, 3);
        checkOutput("B zero at_target", atTargetB, 1);
        checkOutput("B zero busy", busyB, 0);

`ifdef MOTOR_DRIVE_WDOG_EN
        $display("[TB] watchdog trip");
        applyStimulus(0, 2'b11, 10'd40, a);
        pushEvt(0, 2'b11, 10'd0, a + 1);
        pushEvt(0, 2'b11, 10'd8, a + 5);
        pushEvt(0, 2'b11, 10'd16, a + 9);
        pushEvt(0, 2'b11, 10'd24, a + 13);
        pushEvt(0, 2'b11, 10'd32, a + 17);
        pushEvt(0, 2'b11, 10'd40, a + 21);
        waitUntil(a + 199);
        checkOutput("wdog before trip", wdogTripA, 0);
        waitUntil(a + 200);
        checkOutput("wdog trip", wdogTripA, 1);
        pushEvt(0, 2'b11, 10'd32, a + 205);
        pushEvt(0, 2'b11, 10'd24, a + 209);
        pushEvt(0, 2'b11, 10'd16, a + 213);
        pushEvt(0, 2'b11, 10'd8, a + 217);
        pushEvt(0, 2'b11, 10'd0, a + 221);
        pushEvt(0, 2'b00, 10'd0, a + 222);
        waitDrain(60);
        waitUntil(a + 240);
        checkOutput("wdog stopped busy", busyA, 0);
        applyStimulus(0, 2'b11, 10'd8, a);
        checkOutput("wdog cleared", wdogTripA, 0);
        pushEvt(0, 2'b11, 10'd0, a + 1);
        pushEvt(0, 2'b11, 10'd8, a + 5);
        waitDrain(20);
`endif

        checkOutput("leftover expectations", expA.size() + expB.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
